exe_wb_arbiter: RTL and testbench
=================================

EXE_WB_ARBITER -- requirements
Module: exe_wb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 8: number of functional-unit result channels.
REQ-002 Parameter DEPTH, default 2: per-channel result buffer entries, power of two, >= 2.
REQ-003 Parameter XLEN, default 32: result data width.
REQ-004 Parameter ROB_W, default 3: ROB index width.
REQ-005 Parameter RD_W, default 7: physical destination register width.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 fu_valid  input  NUM_FU  per-channel result valid.
REQ-009 fu_ready  output  NUM_FU  per-channel buffer can accept a result.
REQ-010 fu_data  input  NUM_FU x XLEN  per-channel result data.
REQ-011 fu_rob_idx  input  NUM_FU x ROB_W  per-channel ROB index.
REQ-012 fu_rd  input  NUM_FU x RD_W  per-channel destination register.
REQ-013 flush  input  1  mispredict squash; discards all in-flight results.
REQ-014 wb_valid  output  1  registered writeback valid.
REQ-015 wb_data  output  XLEN  registered writeback data.
REQ-016 wb_rob_idx  output  ROB_W  registered writeback ROB index.
REQ-017 wb_rd  output  RD_W  registered writeback destination register.
REQ-018 grant  output  NUM_FU  one-hot combinational grant this cycle; zero when nothing is selected.

Function
REQ-019 A transfer on channel i occurs when fu_valid[i] and fu_ready[i] are both high at a clock edge.
REQ-020 fu_ready[i] is high when channel i holds fewer than DEPTH entries; it does not anticipate a same-cycle dequeue.
REQ-021 Candidate for channel i: FIFO head if non-empty, else the live input when fu_valid[i] && fu_ready[i] (bypass).
REQ-022 Exactly one candidate is granted per cycle when any exists; the granted result appears on wb_* one cycle later with wb_valid=1.
REQ-023 A granted bypass input is not enqueued; a non-granted accepted input is enqueued at the tail.
REQ-024 Same-cycle enqueue and dequeue on one channel leaves its count unchanged and preserves FIFO order.
REQ-025 Per-channel order is strictly FIFO; the live input never overtakes a non-empty buffer.
REQ-026 When no candidate exists, wb_valid=0 next cycle and wb_data, wb_rob_idx, wb_rd hold their previous values.
REQ-027 When flush=1 at an edge, all FIFOs become empty, wb_valid=0 next cycle, and inputs offered that cycle are dropped; grant is forced to zero during flush.
REQ-028 FIFO pointers wrap modulo DEPTH; count ranges 0..DEPTH inclusive.

Reset
REQ-029 On rst: all FIFOs are empty, fu_ready is all ones, wb_valid=0, wb_data/wb_rob_idx/wb_rd=0, and the round-robin pointer=0.
REQ-030 rst has priority over flush and over any transfer in the same cycle; buffered results present when rst asserts are discarded.

Configuration
REQ-031 With WB_RR_ARB_EN defined: round-robin arbitration; the search starts at the channel after the last granted one and wraps from NUM_FU-1 to 0; the pointer updates only on a grant.
REQ-032 Without WB_RR_ARB_EN: fixed priority, lowest channel index wins; no pointer state is instantiated.

Structure
REQ-033 The shared package holds the wb_entry_t struct (data, rob_idx, rd) and the FU channel index constants (ALU=0, MUL=1, DIV=2, FALU=3, FMUL=4, FDIV=5, LOAD=6, STORE=7).
REQ-034 Each channel buffer is one instance of sub-module wb_fifo (parameters DEPTH and entry type; outputs count, head, and empty/full flags); arbitration stays in exe_wb_arbiter.

Verification
REQ-035 Single channel: after reset, fu_valid[0]=1 with data 0x11, rob 2, rd 5 for one cycle -> next cycle wb_valid=1, wb_data=0x11, wb_rob_idx=2, wb_rd=5, and channel 0 stays empty.
REQ-036 Contention, fixed priority: channels 1, 3, 6 valid in the same cycle with data 0xA1/0xA3/0xA6 -> wb_data is 0xA1, 0xA3, 0xA6 on three consecutive cycles.
REQ-037 Contention, WB_RR_ARB_EN: channels 0 and 1 valid every cycle -> grants alternate 0,1,0,1 with no channel granted twice in a row.
REQ-038 Backpressure, DEPTH=2: channel 6 valid for 4 cycles while channel 0 always wins (fixed priority) -> fu_ready[6] falls after 2 entries are buffered; channel 6 results are later written back in issue order.
REQ-039 Flush: 2 entries buffered on channel 3 and flush=1 -> next cycle wb_valid=0, fu_ready[3]=1, and the flushed entries never appear on wb_*.
REQ-040 Reset mid-operation: rst while channels 1 and 6 hold entries -> all wb_* outputs zero, fu_ready all ones, and no stale result appears on wb_* after reset deasserts.

Source files
------------

// File: rtl/exe_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// exe_wb_arbiter_pkg
//   Shared types and constants for the execute-stage writeback arbiter.
//   - wb_entry_t : one buffered FU result (data, ROB index, destination reg),
//                  sized for the default configuration. wb_fifo uses it as its
//                  default entry type; the arbiter passes its own
//                  parameter-sized struct with the same field layout.
//   - FU_*       : functional-unit channel indices on the fu_* buses.
// ---------------------------------------------------------------------------
package exe_wb_arbiter_pkg;

  localparam int WB_XLEN  = 32;
  localparam int WB_ROB_W = 3;
  localparam int WB_RD_W  = 7;

  typedef struct packed {
    logic [WB_XLEN-1:0]  data;
    logic [WB_ROB_W-1:0] rob_idx;
    logic [WB_RD_W-1:0]  rd;
  } wb_entry_t;

  // Functional-unit channel map
  localparam int FU_ALU   = 0;
  localparam int FU_MUL   = 1;
  localparam int FU_DIV   = 2;
  localparam int FU_FALU  = 3;
  localparam int FU_FMUL  = 4;
  localparam int FU_FDIV  = 5;
  localparam int FU_LOAD  = 6;
  localparam int FU_STORE = 7;
  localparam int FU_NUM   = 8;

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
//   Per-channel result buffer for the writeback arbiter. DEPTH entries
//   (power of two, >= 2), pointers wrap naturally modulo DEPTH.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     clr        discard all entries (squash)
//     push       enqueue push_data at the tail (ignored when full)
//     pop        drop the head entry (ignored when empty)
//     count      occupancy 0..DEPTH
//     head       oldest entry (undefined content when empty)
//     empty/full occupancy flags
//   Simultaneous push and pop keep count unchanged and preserve order.
// ---------------------------------------------------------------------------
module wb_fifo
  import exe_wb_arbiter_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output entry_t                     head,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/exe_wb_arbiter.sv
// ---------------------------------------------------------------------------
// exe_wb_arbiter
//   Collects results from NUM_FU functional units, buffers each channel in a
//   DEPTH-entry FIFO and writes back one result per cycle on a registered
//   wb_* port.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     fu_valid/fu_ready        per-channel valid/ready handshake
//     fu_data/fu_rob_idx/fu_rd per-channel result payload
//     flush                    squash: empties all buffers, drops inputs
//     wb_valid/wb_data/
//     wb_rob_idx/wb_rd         registered writeback (payload holds when idle)
//     grant                    one-hot combinational grant this cycle
//   Configuration macro:
//     WB_RR_ARB_EN  defined   -> round-robin arbitration, search starts one
//                                past the last granted channel
//                   undefined -> fixed priority, lowest channel index wins
//   A channel's candidate is its FIFO head, or the live input when the FIFO
//   is empty (bypass), so the live input never overtakes buffered results.
// ---------------------------------------------------------------------------
module exe_wb_arbiter
  import exe_wb_arbiter_pkg::*;
#(
  parameter int NUM_FU = 8,
  parameter int DEPTH  = 2,
  parameter int XLEN   = 32,
  parameter int ROB_W  = 3,
  parameter int RD_W   = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_FU-1:0]             fu_valid,
  output logic [NUM_FU-1:0]             fu_ready,
  input  logic [NUM_FU-1:0][XLEN-1:0]   fu_data,
  input  logic [NUM_FU-1:0][ROB_W-1:0]  fu_rob_idx,
  input  logic [NUM_FU-1:0][RD_W-1:0]   fu_rd,
  input  logic                          flush,
  output logic                          wb_valid,
  output logic [XLEN-1:0]               wb_data,
  output logic [ROB_W-1:0]              wb_rob_idx,
  output logic [RD_W-1:0]               wb_rd,
  output logic [NUM_FU-1:0]             grant
);

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [ROB_W-1:0] rob_idx;
    logic [RD_W-1:0]  rd;
  } entry_t;

  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_FU-1:0]            empty, full, acc, cand, push, pop;
  logic [NUM_FU-1:0][CNT_W-1:0] count;
  entry_t [NUM_FU-1:0]          head, live, cand_e;
  entry_t                       sel_e;
  logic                         any_grant;
  logic [IDX_W-1:0]             gnt_idx;

  // Ready reflects occupancy only; a same-cycle dequeue does not free a slot.
  assign fu_ready = ~full;
  assign acc      = fu_valid & fu_ready;
  // Nothing is eligible during a squash, which also zeroes grant.
  assign cand     = flush ? '0 : (~empty | acc);

  // -------------------------------------------------------------------------
  // Per-channel buffers
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_FU; i++) begin : g_ch
    assign live[i]   = '{data: fu_data[i], rob_idx: fu_rob_idx[i], rd: fu_rd[i]};
    assign cand_e[i] = empty[i] ? live[i] : head[i];
    assign pop[i]    = grant[i] & ~empty[i];
    // A bypassed input goes straight to writeback and is not stored.
    assign push[i]   = acc[i] & ~(grant[i] & empty[i]) & ~flush;

    wb_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .push      (push[i]),
      .push_data (live[i]),
      .pop       (pop[i]),
      .count     (count[i]),
      .head      (head[i]),
      .empty     (empty[i]),
      .full      (full[i])
    );

    always_ff @(posedge clk) begin
      if (!rst) assert (count[i] <= CNT_W'(DEPTH));
    end
  end

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
`ifdef WB_RR_ARB_EN
  // rr_ptr is the first channel searched; it moves one past each grant.
  logic [IDX_W-1:0] rr_ptr;

  always_comb begin
    int idx;
    idx       = 0;
    any_grant = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!any_grant && cand[idx[IDX_W-1:0]]) begin
        any_grant = 1'b1;
        gnt_idx   = idx[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (any_grant)
      rr_ptr <= (gnt_idx == IDX_W'(NUM_FU - 1)) ? '0 : gnt_idx + IDX_W'(1);
  end
`else
  // Scan high to low so the lowest candidate index is the last one kept.
  always_comb begin
    any_grant = 1'b0;
    gnt_idx   = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      if (cand[k]) begin
        any_grant = 1'b1;
        gnt_idx   = IDX_W'(k);
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (any_grant) grant[gnt_idx] = 1'b1;
  end

  assign sel_e = cand_e[gnt_idx];

  // -------------------------------------------------------------------------
  // Writeback register: payload holds when nothing is granted.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rob_idx <= '0;
      wb_rd      <= '0;
    end else begin
      wb_valid <= any_grant;
      if (any_grant) begin
        wb_data    <= sel_e.data;
        wb_rob_idx <= sel_e.rob_idx;
        wb_rd      <= sel_e.rd;
      end
    end
  end

endmodule

// File: tb/tb_exe_wb_arbiter.sv
module tb_exe_wb_arbiter;
  import exe_wb_arbiter_pkg::*;

  localparam int N  = 8;
  localparam int D  = 2;
  localparam int XL = 32;
  localparam int RW = 3;
  localparam int DW = 7;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush = 1'b0;
  logic [N-1:0]         fu_valid = '0;
  logic [N-1:0]         fu_ready, grant;
  logic [N-1:0][XL-1:0] fu_data = '0;
  logic [N-1:0][RW-1:0] fu_rob_idx = '0;
  logic [N-1:0][DW-1:0] fu_rd = '0;
  logic                 wb_valid;
  logic [XL-1:0]        wb_data;
  logic [RW-1:0]        wb_rob_idx;
  logic [DW-1:0]        wb_rd;

  exe_wb_arbiter #(.NUM_FU(N), .DEPTH(D), .XLEN(XL), .ROB_W(RW), .RD_W(DW)) dut (
    .clk(clk), .rst(rst), .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_data(fu_data), .fu_rob_idx(fu_rob_idx), .fu_rd(fu_rd), .flush(flush),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rob_idx(wb_rob_idx),
    .wb_rd(wb_rd), .grant(grant)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model: one queue per channel ----------------
  typedef struct packed {
    logic [XL-1:0] d;
    logic [RW-1:0] r;
    logic [DW-1:0] rd;
  } ent_t;

  ent_t          mq[N][$];
  logic          m_valid = 1'b0;
  logic [XL-1:0] m_data = '0;
  logic [RW-1:0] m_rob = '0;
  logic [DW-1:0] m_rd = '0;
  int            m_rr = 0;
  bit            armed = 1'b0;

  int            nvec = 0;
  int            nerr = 0;
  int            seen_rd[N];
  logic [XL-1:0] got6[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ent_t live(int i);
    return '{d: fu_data[i], r: fu_rob_idx[i], rd: fu_rd[i]};
  endfunction

  // Which channel must win this cycle, or -1.
  function automatic int pick();
    int c;
    if (flush) return -1;
    for (int k = 0; k < N; k++) begin
`ifdef WB_RR_ARB_EN
      c = (m_rr + k) % N;
`else
      c = k;
`endif
      if (mq[c].size() > 0 || (fu_valid[c] && mq[c].size() < D)) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int   g;
    bit   acc[N];
    bit   was_empty[N];
    ent_t e;
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_valid = 1'b0; m_data = '0; m_rob = '0; m_rd = '0; m_rr = 0;
      armed = 1'b1;
    end else if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_valid = 1'b0;
    end else begin
      g = pick();
      for (int i = 0; i < N; i++) begin
        acc[i]       = fu_valid[i] && (mq[i].size() < D);
        was_empty[i] = (mq[i].size() == 0);
      end
      m_valid = (g >= 0);
      if (g >= 0) begin
        if (was_empty[g]) e = live(g);
        else              e = mq[g].pop_front();
        m_data = e.d; m_rob = e.r; m_rd = e.rd;
        m_rr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (acc[i] && !(i == g && was_empty[i])) mq[i].push_back(live(i));
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    int           g;
    logic [N-1:0] eg, er;
    if (armed) begin
      g  = pick();
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      for (int i = 0; i < N; i++) er[i] = (mq[i].size() < D);
      if (!rst) chk("grant", grant, eg);
      chk("fu_ready", fu_ready, er);
      chk("wb_valid", wb_valid, m_valid);
      chk("wb_data", wb_data, m_data);
      chk("wb_rob_idx", wb_rob_idx, m_rob);
      chk("wb_rd", wb_rd, m_rd);
      if (wb_valid === 1'b1) begin
        if (int'(wb_rd) < N) seen_rd[int'(wb_rd)]++;
        if (wb_rd == 7'd6) got6.push_back(wb_data);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int ch, logic [XL-1:0] d, logic [RW-1:0] r, logic [DW-1:0] rd);
    fu_valid[ch]   = 1'b1;
    fu_data[ch]    = d;
    fu_rob_idx[ch] = r;
    fu_rd[ch]      = rd;
  endtask

  initial begin
    logic [7:0] masks [8];
    int         idx;
    bit         acc6;
    masks = '{8'hFF, 8'hFF, 8'hFF, 8'h81, 8'h00, 8'h3C, 8'h42, 8'h00};

    // Reset state
    rst = 1'b1;
    repeat (2) step();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_fu_ready", fu_ready, 8'hFF);
    rst = 1'b0;

`ifdef WB_RR_ARB_EN
    // Round robin: channels 0 and 1 always valid -> 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      fu_valid = '0;
      drive(FU_ALU, 32'hE0 + k, 0, 0);
      drive(FU_MUL, 32'hE8 + k, 0, 1);
      #1;
      chk("rr_grant", grant, (k % 2 == 0) ? 64'h01 : 64'h02);
      step();
    end
    fu_valid = '0;
    repeat (4) step();
`endif

    // Single channel bypass
    fu_valid = '0;
    drive(FU_ALU, 32'h11, 3'd2, 7'd5);
    step();
    fu_valid = '0;
    #1;
    chk("single_wb_valid", wb_valid, 1);
    chk("single_wb_data", wb_data, 32'h11);
    chk("single_wb_rob", wb_rob_idx, 2);
    chk("single_wb_rd", wb_rd, 5);
    chk("single_model_data", m_data, 32'h11);
    chk("single_ch0_empty", grant, 0);
    step();
    chk("idle_wb_valid", wb_valid, 0);
    chk("idle_wb_hold", wb_data, 32'h11);

`ifndef WB_RR_ARB_EN
    // Fixed-priority contention: channels 1, 3, 6
    drive(FU_MUL, 32'hA1, 1, 1);
    drive(FU_FALU, 32'hA3, 3, 3);
    drive(FU_LOAD, 32'hA6, 6, 0);
    step();
    fu_valid = '0;
    chk("prio_first", wb_data, 32'hA1);
    step();
    chk("prio_second", wb_data, 32'hA3);
    step();
    chk("prio_third", wb_data, 32'hA6);
    chk("prio_model_third", m_data, 32'hA6);
    step();
    chk("prio_idle", wb_valid, 0);

    // Backpressure on channel 6 while channel 0 keeps winning
    idx = 0;
    got6.delete();
    for (int cyc = 0; cyc < 14; cyc++) begin
      fu_valid = '0;
      if (cyc < 6) drive(FU_ALU, 32'hB0 + cyc, 0, 0);
      if (idx < 4) drive(FU_LOAD, 32'hC0 + idx, 1, 6);
      #1;
      if (cyc == 2) chk("bp_ready_low", fu_ready[FU_LOAD], 0);
      acc6 = fu_valid[FU_LOAD] && fu_ready[FU_LOAD];
      step();
      if (acc6) idx++;
    end
    fu_valid = '0;
    chk("bp_count", got6.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("bp_order", (k < got6.size()) ? got6[k] : 'x, 32'hC0 + k);
`endif

    // Mixed directed vectors, then drain
    for (int t = 0; t < 8; t++) begin
      fu_valid = masks[t];
      for (int i = 0; i < N; i++) begin
        fu_data[i]    = 32'h1000 + t * 256 + i;
        fu_rob_idx[i] = 3'(i + t);
        fu_rd[i]      = 7'(i);
      end
      step();
    end
    fu_valid = '0;
    repeat (20) step();

`ifndef WB_RR_ARB_EN
    // Flush with two entries parked on channel 3
    for (int i = 0; i < N; i++) seen_rd[i] = 0;
    for (int k = 0; k < 2; k++) begin
      fu_valid = '0;
      drive(FU_ALU, 32'h50 + k, 0, 0);
      drive(FU_FALU, 32'hD0 + k, 3, 3);
      step();
    end
    fu_valid = '0;
    drive(FU_FDIV, 32'hE5, 5, 5);
    flush = 1'b1;
    #1;
    chk("flush_grant", grant, 0);
    step();
    flush = 1'b0;
    fu_valid = '0;
    chk("flush_wb_valid", wb_valid, 0);
    chk("flush_ready3", fu_ready[FU_FALU], 1);
    repeat (4) step();
    chk("flush_no_ch3", seen_rd[3], 0);
    chk("flush_no_dropped", seen_rd[5], 0);
`endif

    // Reset mid-operation with entries on channels 1 and 6
    for (int k = 0; k < 2; k++) begin
      fu_valid = '0;
      drive(FU_ALU, 32'h60 + k, 0, 0);
      drive(FU_MUL, 32'hF1 + k, 1, 1);
      drive(FU_LOAD, 32'hF6 + k, 6, 6);
      step();
    end
    fu_valid = 8'hFF;
    rst = 1'b1;
    flush = 1'b1;
    step();
    rst = 1'b0;
    flush = 1'b0;
    fu_valid = '0;
    chk("rst2_wb_valid", wb_valid, 0);
    chk("rst2_wb_data", wb_data, 0);
    chk("rst2_wb_rob", wb_rob_idx, 0);
    chk("rst2_wb_rd", wb_rd, 0);
    chk("rst2_fu_ready", fu_ready, 8'hFF);
    for (int i = 0; i < N; i++) seen_rd[i] = 0;
    repeat (4) step();
    chk("rst2_no_stale_ch1", seen_rd[1], 0);
    chk("rst2_no_stale_ch6", seen_rd[6], 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
